// File: rtl/led_status_if.sv
// Signal bundle between the status-code source and the LED status sequencer.
// The master side supplies codes and the fault level; the slave side (the
// sequencer) returns the tick, acknowledge, busy flag and LED requests.
interface led_status_if;
  logic [3:0] code_in;
  logic       code_valid;
  logic       fault_in;
  logic       tick_12hz;
  logic       code_ack;
  logic       busy;
  logic       led_grn;
  logic       led_red;

  modport master (
    output code_in, code_valid, fault_in,
    input  tick_12hz, code_ack, busy, led_grn, led_red
  );

  modport slave (
    input  code_in, code_valid, fault_in,
    output tick_12hz, code_ack, busy, led_grn, led_red
  );
endinterface

// File: rtl/led_status_seq.sv
// LED status sequencer: blinks the red LED N times for status code N, with a
// dark gap between repeats, shows steady green when healthy and steady red
// while a fault is present. All sequencing advances on a 12 Hz tick derived
// from sysclk by a free-running prescaler.
module led_status_seq #(
  parameter int unsigned CLK_DIV   = 4096000, // sysclk cycles per tick
  parameter int unsigned ON_TICKS  = 3,       // ticks lit per blink, >= 1
  parameter int unsigned OFF_TICKS = 3,       // ticks dark between blinks, >= 1
  parameter int unsigned GAP_TICKS = 12       // dark ticks after last blink, >= 1
) (
  input logic         sysclk,
  input logic         reset,   // synchronous, active-low
  led_status_if.slave bus
);

  localparam int unsigned PRE_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned PH_MAX =
    (ON_TICKS > OFF_TICKS) ? ((ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS)
                           : ((OFF_TICKS > GAP_TICKS) ? OFF_TICKS : GAP_TICKS);
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  ON_LAST  = PH_W'(ON_TICKS - 1);
  localparam logic [PH_W-1:0]  OFF_LAST = PH_W'(OFF_TICKS - 1);
  localparam logic [PH_W-1:0]  GAP_LAST = PH_W'(GAP_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    ON,
    OFF,
    GAP,
    FAULT
  } state_t;

  state_t           state, state_nxt;
  logic [PRE_W-1:0] pre_cnt;
  logic [PH_W-1:0]  ph_cnt;
  logic [3:0]       pending;
  logic [3:0]       active;
  logic [3:0]       blink_cnt;
  logic             tick;
  logic             accept;
  logic             blink_dec;

  assign tick          = (pre_cnt == PRE_LAST);
  assign bus.tick_12hz = tick;
  assign bus.code_ack  = accept;

  // Prescaler: counts 0..CLK_DIV-1 and wraps; tick marks the last count.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge sysclk) begin
    if (!reset)
      pre_cnt <= '0;
    else if (tick)
      pre_cnt <= '0;
    else
      pre_cnt <= pre_cnt + PRE_W'(1);
  end

  // Pending code: last qualified load wins, held otherwise; fault leaves it alone.
  always_ff @(posedge sysclk) begin
    if (!reset)
      pending <= '0;
    else if (bus.code_valid)
      pending <= bus.code_in;
  end

  // Next-state logic: tick-paced sequencing with fault as an immediate override.
  // NOTE: every output of this block gets a default first so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    blink_dec = 1'b0;
    case (state)
      IDLE: begin
        if (tick && (pending != 4'd0)) begin
          state_nxt = ON;
          accept    = 1'b1;
        end
      end
      ON: begin
        if (tick && (ph_cnt == ON_LAST))
          state_nxt = OFF;
      end
      OFF: begin
        if (tick && (ph_cnt == OFF_LAST)) begin
          blink_dec = 1'b1;
          state_nxt = (blink_cnt == 4'd1) ? GAP : ON;
        end
      end
      GAP: begin
        if (tick && (ph_cnt == GAP_LAST))
          state_nxt = IDLE;
      end
      FAULT: begin
        if (tick && !bus.fault_in)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Fault beats everything, including a same-cycle acceptance.
    if (bus.fault_in) begin
      state_nxt = FAULT;
      accept    = 1'b0;
      blink_dec = 1'b0;
    end
  end

  // State register and phase counter; the phase restarts on every state change.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state  <= IDLE;
      ph_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        ph_cnt <= '0;
      else if (tick && ((state == ON) || (state == OFF) || (state == GAP)))
        ph_cnt <= ph_cnt + PH_W'(1);
    end
  end

  // Active code and remaining blinks, latched at acceptance so later pending
  // changes cannot disturb a running sequence.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      active    <= '0;
      blink_cnt <= '0;
    end else if (accept) begin
      active    <= pending;
      blink_cnt <= pending;
    end else if (blink_dec) begin
      blink_cnt <= blink_cnt - 4'd1;
    end
  end

  // Remaining blinks can never exceed the code being displayed.
  always_ff @(posedge sysclk) begin
    if (reset)
      assert (blink_cnt <= active);
  end

  // Registered LED/busy decode of the current state (one cycle behind it).
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      bus.led_grn <= 1'b0;
      bus.led_red <= 1'b0;
      bus.busy    <= 1'b0;
    end else begin
      bus.led_grn <= (state == IDLE);
      bus.led_red <= (state == ON) || (state == FAULT);
      bus.busy    <= (state != IDLE);
    end
  end

endmodule

// File: tb/tb_led_status_seq.sv
// Directed bench for led_status_seq with CLK_DIV=4, ON=2, OFF=2, GAP=4.
// Vector records carry the inputs for a given cycle after reset release and
// the expected {grn, red, busy, ack, tick} seen in that cycle.
module tb_led_status_seq;

  logic sysclk;
  logic reset;
  led_status_if bus();

  led_status_seq #(
    .CLK_DIV  (4),
    .ON_TICKS (2),
    .OFF_TICKS(2),
    .GAP_TICKS(4)
  ) dut (
    .sysclk(sysclk),
    .reset (reset),
    .bus   (bus)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  typedef struct {
    bit         rb;   // apply a fresh reset before this record
    int         cyc;  // cycle index after reset release
    bit         rs;   // reset level to drive
    bit         vl;   // code_valid
    logic [3:0] cd;   // code_in
    bit         fl;   // fault_in
    logic [4:0] ex;   // expected {grn, red, busy, ack, tick}
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;
  int   cur   = 0;

  task automatic v(input bit rb, input int cyc, input bit rs, input bit vl,
                   input logic [3:0] cd, input bit fl, input logic [4:0] ex);
    vec_t t;
    t.rb = rb; t.cyc = cyc; t.rs = rs; t.vl = vl; t.cd = cd; t.fl = fl; t.ex = ex;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge sysclk);
    #1;
    cur++;
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    bus.code_valid = 1'b0;
    bus.code_in    = 4'd0;
    bus.fault_in   = 1'b0;
    repeat (2) begin
      @(posedge sysclk);
      #1;
    end
    cur = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         acks, rises, high, ack_cyc;
    bit         cleared;
    logic       prev_red;
    logic [4:0] got;

    // Code 0 loaded: free-running tick, no ack, green stays on.
    v(1,  0, 1, 1, 4'd0, 0, 5'b00000);
    v(0,  1, 1, 0, 4'd0, 0, 5'b10000);
    v(0,  2, 1, 0, 4'd0, 0, 5'b10000);
    v(0,  3, 1, 0, 4'd0, 0, 5'b10001);
    v(0,  4, 1, 0, 4'd0, 0, 5'b10000);
    v(0,  7, 1, 0, 4'd0, 0, 5'b10001);
    v(0,  8, 1, 0, 4'd0, 0, 5'b10000);
    v(0, 11, 1, 0, 4'd0, 0, 5'b10001);
    v(0, 20, 1, 0, 4'd0, 0, 5'b10000);
    // Code 3, then pending cleared mid-sequence: 3 blinks, gap, idle for good.
    v(1,  0, 1, 1, 4'd3, 0, 5'b00000);
    v(0,  1, 1, 0, 4'd3, 0, 5'b10000);
    v(0,  3, 1, 0, 4'd3, 0, 5'b10011);
    v(0,  4, 1, 0, 4'd3, 0, 5'b10000);
    v(0,  5, 1, 0, 4'd3, 0, 5'b01100);
    v(0,  6, 1, 1, 4'd0, 0, 5'b01100);
    v(0,  7, 1, 0, 4'd0, 0, 5'b01101);
    v(0, 12, 1, 0, 4'd0, 0, 5'b01100);
    v(0, 13, 1, 0, 4'd0, 0, 5'b00100);
    v(0, 20, 1, 0, 4'd0, 0, 5'b00100);
    v(0, 21, 1, 0, 4'd0, 0, 5'b01100);
    v(0, 28, 1, 0, 4'd0, 0, 5'b01100);
    v(0, 29, 1, 0, 4'd0, 0, 5'b00100);
    v(0, 37, 1, 0, 4'd0, 0, 5'b01100);
    v(0, 44, 1, 0, 4'd0, 0, 5'b01100);
    v(0, 45, 1, 0, 4'd0, 0, 5'b00100);
    v(0, 53, 1, 0, 4'd0, 0, 5'b00100);
    v(0, 68, 1, 0, 4'd0, 0, 5'b00100);
    v(0, 69, 1, 0, 4'd0, 0, 5'b10000);
    v(0, 71, 1, 0, 4'd0, 0, 5'b10001);
    v(0, 76, 1, 0, 4'd0, 0, 5'b10000);
    // Code 3, changed to 5 mid-sequence: 3 blinks, gap, then 5 blinks.
    v(1,   0, 1, 1, 4'd3, 0, 5'b00000);
    v(0,   1, 1, 0, 4'd3, 0, 5'b10000);
    v(0,   3, 1, 0, 4'd3, 0, 5'b10011);
    v(0,   6, 1, 1, 4'd5, 0, 5'b01100);
    v(0,   7, 1, 0, 4'd5, 0, 5'b01101);
    v(0,  44, 1, 0, 4'd5, 0, 5'b01100);
    v(0,  45, 1, 0, 4'd5, 0, 5'b00100);
    v(0,  53, 1, 0, 4'd5, 0, 5'b00100);
    v(0,  69, 1, 0, 4'd5, 0, 5'b10000);
    v(0,  71, 1, 0, 4'd5, 0, 5'b10011);
    v(0,  72, 1, 0, 4'd5, 0, 5'b10000);
    v(0,  73, 1, 0, 4'd5, 0, 5'b01100);
    v(0,  80, 1, 0, 4'd5, 0, 5'b01100);
    v(0,  81, 1, 0, 4'd5, 0, 5'b00100);
    v(0,  89, 1, 0, 4'd5, 0, 5'b01100);
    v(0, 137, 1, 0, 4'd5, 0, 5'b01100);
    v(0, 144, 1, 0, 4'd5, 0, 5'b01100);
    v(0, 145, 1, 0, 4'd5, 0, 5'b00100);
    v(0, 153, 1, 0, 4'd5, 0, 5'b00100);
    v(0, 168, 1, 0, 4'd5, 0, 5'b00100);
    v(0, 169, 1, 0, 4'd5, 0, 5'b10000);
    // Code 4 with a fault during the second ON: steady red, then full replay.
    v(1,   0, 1, 1, 4'd4, 0, 5'b00000);
    v(0,   1, 1, 0, 4'd4, 0, 5'b10000);
    v(0,   3, 1, 0, 4'd4, 0, 5'b10011);
    v(0,  21, 1, 0, 4'd4, 0, 5'b01100);
    v(0,  22, 1, 0, 4'd4, 1, 5'b01100);
    v(0,  23, 1, 0, 4'd4, 1, 5'b01101);
    v(0,  24, 1, 0, 4'd4, 1, 5'b01100);
    v(0,  28, 1, 0, 4'd4, 1, 5'b01100);
    v(0,  30, 1, 0, 4'd4, 0, 5'b01100);
    v(0,  31, 1, 0, 4'd4, 0, 5'b01101);
    v(0,  32, 1, 0, 4'd4, 0, 5'b01100);
    v(0,  33, 1, 0, 4'd4, 0, 5'b10000);
    v(0,  35, 1, 0, 4'd4, 0, 5'b10011);
    v(0,  37, 1, 0, 4'd4, 0, 5'b01100);
    v(0,  44, 1, 0, 4'd4, 0, 5'b01100);
    v(0,  45, 1, 0, 4'd4, 0, 5'b00100);
    v(0,  53, 1, 0, 4'd4, 0, 5'b01100);
    v(0,  85, 1, 0, 4'd4, 0, 5'b01100);
    v(0,  92, 1, 0, 4'd4, 0, 5'b01100);
    v(0,  93, 1, 0, 4'd4, 0, 5'b00100);
    v(0, 101, 1, 0, 4'd4, 0, 5'b00100);
    v(0, 116, 1, 0, 4'd4, 0, 5'b00100);
    v(0, 117, 1, 0, 4'd4, 0, 5'b10000);
    // Fault on the acceptance tick: no ack, FAULT first, accepted next tick.
    v(1,  0, 1, 1, 4'd2, 0, 5'b00000);
    v(0,  1, 1, 0, 4'd2, 0, 5'b10000);
    v(0,  3, 1, 0, 4'd2, 1, 5'b10001);
    v(0,  4, 1, 0, 4'd2, 0, 5'b10000);
    v(0,  5, 1, 0, 4'd2, 0, 5'b01100);
    v(0,  7, 1, 0, 4'd2, 0, 5'b01101);
    v(0,  8, 1, 0, 4'd2, 0, 5'b01100);
    v(0,  9, 1, 0, 4'd2, 0, 5'b10000);
    v(0, 11, 1, 0, 4'd2, 0, 5'b10011);
    v(0, 13, 1, 0, 4'd2, 0, 5'b01100);
    // Reset during OFF: outputs cleared, then green with no residual blinks.
    v(1,  0, 1, 1, 4'd3, 0, 5'b00000);
    v(0,  1, 1, 0, 4'd3, 0, 5'b10000);
    v(0,  3, 1, 0, 4'd3, 0, 5'b10011);
    v(0, 14, 0, 0, 4'd3, 0, 5'b00100);
    v(0, 15, 0, 0, 4'd3, 0, 5'b00000);
    v(0, 16, 1, 0, 4'd3, 0, 5'b00000);
    v(0, 17, 1, 0, 4'd3, 0, 5'b10000);
    v(0, 19, 1, 0, 4'd3, 0, 5'b10001);
    v(0, 30, 1, 0, 4'd3, 0, 5'b10000);
    v(0, 50, 1, 0, 4'd3, 0, 5'b10000);
    v(0, 80, 1, 0, 4'd3, 0, 5'b10000);

    foreach (vecs[i]) begin
      if (vecs[i].rb)
        do_reset();
      while (cur < vecs[i].cyc)
        step();
      reset          = vecs[i].rs;
      bus.code_valid = vecs[i].vl;
      bus.code_in    = vecs[i].cd;
      bus.fault_in   = vecs[i].fl;
      #1;
      got = {bus.led_grn, bus.led_red, bus.busy, bus.code_ack, bus.tick_12hz};
      check($sformatf("vec%0d_cyc%0d_grbat", i, vecs[i].cyc), int'(got), int'(vecs[i].ex));
    end

    // Two back-to-back loads (7 then 2): the last one wins, giving 2 blinks.
    do_reset();
    reset          = 1'b1;
    bus.code_valid = 1'b1;
    bus.code_in    = 4'd7;
    step();
    bus.code_in    = 4'd2;
    step();
    bus.code_valid = 1'b0;
    acks     = 0;
    rises    = 0;
    high     = 0;
    ack_cyc  = -1;
    cleared  = 1'b0;
    prev_red = 1'b0;
    for (int k = 0; k < 120; k++) begin
      step();
      bus.code_valid = 1'b0;
      if (acks == 1 && !cleared) begin
        bus.code_valid = 1'b1;
        bus.code_in    = 4'd0;
        cleared        = 1'b1;
      end
      #1;
      if (bus.code_ack) begin
        acks++;
        if (ack_cyc < 0)
          ack_cyc = cur;
      end
      if (bus.led_red && !prev_red)
        rises++;
      if (bus.led_red)
        high++;
      prev_red = bus.led_red;
    end
    check("last_wins_ack_count", acks, 1);
    check("last_wins_ack_cycle", ack_cyc, 3);
    check("last_wins_blinks", rises, 2);
    check("last_wins_red_cycles", high, 16);
    check("last_wins_end_grn", int'(bus.led_grn), 1);
    check("last_wins_end_busy", int'(bus.busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_status_seq.md
LED_STATUS_SEQ -- requirements
Module: led_status_seq

Interface
REQ-001 Parameter CLK_DIV, default 4096000, sysclk cycles per tick (49.152 MHz / 12 Hz).
REQ-002 Parameter ON_TICKS, default 3, ticks red is lit per blink.
REQ-003 Parameter OFF_TICKS, default 3, ticks red is dark between blinks.
REQ-004 Parameter GAP_TICKS, default 12, dark ticks after the last blink of a code.
REQ-005 sysclk  input  1  system clock; all logic on its rising edge.
REQ-006 reset  input  1  reset, synchronous, active-low.
REQ-007 code_in  input  4  status code to display; 0 means healthy.
REQ-008 code_valid  input  1  code_in qualifier; loads the pending-code register.
REQ-009 fault_in  input  1  level; fault override.
REQ-010 tick_12hz  output  1  one-sysclk pulse every CLK_DIV cycles.
REQ-011 code_ack  output  1  one-cycle pulse when a pending code is accepted into a display sequence.
REQ-012 busy  output  1  high while a blink sequence or a fault is displayed.
REQ-013 led_grn  output  1  green LED request to the LED mux/PWM stage.
REQ-014 led_red  output  1  red LED request to the LED mux/PWM stage.

Function
REQ-015 Prescaler shall count 0..CLK_DIV-1 and wrap to 0; tick_12hz shall be high for exactly the cycle in which the count equals CLK_DIV-1.
REQ-016 Pending register shall load code_in on every cycle with code_valid=1; the last load wins; the register holds its value otherwise.
REQ-017 The FSM shall have states IDLE, ON, OFF, GAP, FAULT; all state transitions other than entry to FAULT shall occur only on tick cycles.
REQ-018 Phase counter ph_cnt shall clear on every state change and increment on each tick while in ON, OFF or GAP.
REQ-019 IDLE: on a tick with pending!=0, latch active=pending and blink_cnt=pending, pulse code_ack in that same cycle, and go to ON.
REQ-020 IDLE: on a tick with pending=0, stay in IDLE and do not pulse code_ack.
REQ-021 ON: on the tick where ph_cnt=ON_TICKS-1, go to OFF.
REQ-022 OFF: on the tick where ph_cnt=OFF_TICKS-1, decrement blink_cnt; if blink_cnt was 1, go to GAP; otherwise go to ON.
REQ-023 GAP: on the tick where ph_cnt=GAP_TICKS-1, go to IDLE; a code still pending then restarts on the next tick.
REQ-024 Changes to pending during ON, OFF or GAP shall not alter the running sequence; only the latched active code is displayed.
REQ-025 fault_in=1 in any state, on any cycle, shall force FAULT on the next clock and abort any running sequence.
REQ-026 FAULT: on a tick with fault_in=0, go to IDLE; pending shall be unaffected by the fault.
REQ-027 fault_in=1 on the same cycle as an IDLE acceptance tick: fault wins, no code_ack, next state FAULT.
REQ-028 Outputs led_grn, led_red and busy shall be registered and decode the current state with one-cycle latency:
- IDLE: grn=1, red=0, busy=0
- ON: grn=0, red=1, busy=1
- OFF/GAP: grn=0, red=0, busy=1
- FAULT: grn=0, red=1, busy=1
REQ-029 blink_cnt and ph_cnt shall not wrap; OFF_TICKS, ON_TICKS and GAP_TICKS shall each be >=1.

Reset
REQ-030 While reset=0 at a clock edge: state IDLE; prescaler, ph_cnt, blink_cnt, active and pending cleared; tick_12hz, code_ack, busy, led_grn and led_red all 0.
REQ-031 Reset asserted mid-sequence shall abort the sequence with no further blinks; led_grn shall reach 1 two cycles after reset is released.

Verification
REQ-032 Run with CLK_DIV=4, ON=2, OFF=2, GAP=4.
- Free-run: tick_12hz is high on cycles 3, 7, 11 after reset release.
- code 3 loaded: code_ack once; 3 red pulses, each 8 cycles high and 8 low; 16-cycle gap; back to IDLE with grn=1.
- Code changed from 3 to 5 mid-sequence: exactly 3 blinks complete, then 5 blinks start after the gap.
- fault_in pulsed during the second ON of code 4: red steady and busy=1 within 2 cycles; after fault clears, IDLE on the next tick, then code 4 replays from the first blink.
- code 0 loaded: no code_ack, grn stays 1, busy stays 0.
- Reset asserted during OFF: all outputs 0 at the next edge; after release, grn=1 with no residual blinks.
